// File: rtl/mem_dbus.sv
// MEM stage with an integrated request/acknowledge data-bus master.
// Does big-endian byte-lane steering for stores and load extraction, and holds the result while MEM is frozen.

module mem_dbus_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,   // 0 byte, 1 half, 2 word
  input  logic [1:0]  a,
  input  logic [31:0] reg2,
  output logic        sel,
  output logic [7:0]  wbyte
);
  always_comb begin
    sel   = 1'b1;
    wbyte = reg2[8*LANE +: 8];
    case (size)
      2'd0: begin
        // lane 3 holds the lowest byte address
        sel   = (a == 2'(3 - LANE));
        wbyte = reg2[7:0];
      end
      2'd1: begin
        sel   = a[1] ? (LANE < 2) : (LANE >= 2);
        wbyte = reg2[8*(LANE % 2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module mem_dbus (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        mem_whilo_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic        mem_cp0_reg_we_i,
  input  logic [4:0]  mem_cp0_reg_write_addr_i,
  input  logic [31:0] mem_cp0_reg_data_i,
  input  logic [5:0]  stall_i,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic [31:0] wb_hi_o,
  output logic [31:0] wb_lo_o,
  output logic        wb_whilo_o,
  output logic        wb_cp0_reg_we_o,
  output logic [4:0]  wb_cp0_reg_write_addr_o,
  output logic [31:0] wb_cp0_reg_data_o,
  output logic        stallreq_o
);
  localparam int NUM_LANES = 4;

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state;
  logic        is_mem, is_store, is_signed;
  logic [1:0]  size;
  logic [1:0]  cur_size, cur_a;
  logic        cur_signed, cur_store;
  logic [31:0] rd_buf, ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [NUM_LANES-1:0]      lane_sel;
  logic [NUM_LANES-1:0][7:0] lane_wdata;
  logic        unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  always_comb begin
    is_mem    = 1'b1;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = 2'd2;
    case (mem_aluop_i)
      EXE_LB_OP:  begin size = 2'd0; is_signed = 1'b1; end
      EXE_LBU_OP: size = 2'd0;
      EXE_LH_OP:  begin size = 2'd1; is_signed = 1'b1; end
      EXE_LHU_OP: size = 2'd1;
      EXE_LW_OP:  size = 2'd2;
      EXE_SB_OP:  begin size = 2'd0; is_store = 1'b1; end
      EXE_SH_OP:  begin size = 2'd1; is_store = 1'b1; end
      EXE_SW_OP:  begin size = 2'd2; is_store = 1'b1; end
      default:    is_mem = 1'b0;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mem_dbus_lane #(.LANE(l)) u_lane (
      .size  (size),
      .a     (mem_mem_addr_i[1:0]),
      .reg2  (mem_reg2_i),
      .sel   (lane_sel[l]),
      .wbyte (lane_wdata[l])
    );
  end

  // Extraction uses the op latched at issue, so it is independent of the upstream regs.
  always_comb begin
    ld_byte = dbus_rdata_i[{~cur_a, 3'b000} +: 8];
    ld_half = cur_a[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
    case (cur_size)
      2'd0:    ext = {{24{cur_signed & ld_byte[7]}}, ld_byte};
      2'd1:    ext = {{16{cur_signed & ld_half[15]}}, ld_half};
      default: ext = dbus_rdata_i;
    endcase
    if (cur_store) ext = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'h0;
      dbus_sel_o   <= 4'h0;
      dbus_wdata_o <= 32'h0;
      rd_buf       <= 32'h0;
      cur_size     <= 2'd0;
      cur_a        <= 2'd0;
      cur_signed   <= 1'b0;
      cur_store    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_mem) begin
          dbus_req_o   <= 1'b1;
          dbus_we_o    <= is_store;
          dbus_addr_o  <= {mem_mem_addr_i[31:2], 2'b00};
          dbus_sel_o   <= lane_sel;
          dbus_wdata_o <= lane_wdata;
          cur_size     <= size;
          cur_a        <= mem_mem_addr_i[1:0];
          cur_signed   <= is_signed;
          cur_store    <= is_store;
          state        <= BUSY;
        end
        BUSY: if (dbus_ack_i) begin
          dbus_req_o <= 1'b0;
          rd_buf     <= ext;
          state      <= stall_i[4] ? HOLD : IDLE;
        end
        HOLD: if (!stall_i[4]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_wdata_o = 32'h0;
    stallreq_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          stallreq_o = is_mem;
          wb_wdata_o = is_mem ? 32'h0 : mem_wdata_i;
        end
        BUSY: begin
          stallreq_o = !dbus_ack_i;
          wb_wdata_o = dbus_ack_i ? ext : 32'h0;
        end
        HOLD:    wb_wdata_o = rd_buf;
        default: ;
      endcase
    end
  end

  assign wb_wd_o                 = rst ? 5'h0  : mem_wd_i;
  assign wb_wreg_o               = rst ? 1'b0  : mem_wreg_i;
  assign wb_hi_o                 = rst ? 32'h0 : mem_hi_i;
  assign wb_lo_o                 = rst ? 32'h0 : mem_lo_i;
  assign wb_whilo_o              = rst ? 1'b0  : mem_whilo_i;
  assign wb_cp0_reg_we_o         = rst ? 1'b0  : mem_cp0_reg_we_i;
  assign wb_cp0_reg_write_addr_o = rst ? 5'h0  : mem_cp0_reg_write_addr_i;
  assign wb_cp0_reg_data_o       = rst ? 32'h0 : mem_cp0_reg_data_i;
endmodule

// File: tb/tb_mem_dbus.sv
// Directed bench for mem_dbus: a per-cycle timeline model of each transaction plus literal spot checks.

module tb_mem_dbus;
  localparam logic [7:0] LB  = 8'b11100000, LBU = 8'b11100100, LH = 8'b11100001;
  localparam logic [7:0] LHU = 8'b11100101, LW  = 8'b11100011, SB = 8'b11101000;
  localparam logic [7:0] SH  = 8'b11101001, SW  = 8'b11101011, ALU = 8'b00100001;

  logic        clk = 0, rst = 1;
  logic [4:0]  wd = 0, cp0_wa = 0;
  logic        wreg = 0, whilo = 0, cp0_we = 0, ack = 0;
  logic [31:0] wdata = 0, hi = 0, lo = 0, maddr = 0, reg2 = 0, cp0_d = 0, rdata = 0;
  logic [7:0]  aluop = ALU;
  logic [5:0]  stall = 0;

  logic        req_o, we_o, wb_wreg, wb_whilo, wb_cp0_we, stallreq;
  logic [31:0] addr_o, wdata_o, wb_wdata, wb_hi, wb_lo, wb_cp0_d;
  logic [3:0]  sel_o;
  logic [4:0]  wb_wd, wb_cp0_wa;

  // expected values for the current cycle
  logic        e_req = 0, e_we = 0, e_stall = 0, chk_en = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_wb = 0;
  logic [3:0]  e_sel = 0;

  int n_chk = 0, n_fail = 0;

  mem_dbus dut (
    .clk(clk), .rst(rst),
    .mem_wd_i(wd), .mem_wreg_i(wreg), .mem_wdata_i(wdata),
    .mem_hi_i(hi), .mem_lo_i(lo), .mem_whilo_i(whilo),
    .mem_aluop_i(aluop), .mem_mem_addr_i(maddr), .mem_reg2_i(reg2),
    .mem_cp0_reg_we_i(cp0_we), .mem_cp0_reg_write_addr_i(cp0_wa), .mem_cp0_reg_data_i(cp0_d),
    .stall_i(stall), .dbus_ack_i(ack), .dbus_rdata_i(rdata),
    .dbus_req_o(req_o), .dbus_we_o(we_o), .dbus_addr_o(addr_o), .dbus_sel_o(sel_o),
    .dbus_wdata_o(wdata_o),
    .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata),
    .wb_hi_o(wb_hi), .wb_lo_o(wb_lo), .wb_whilo_o(wb_whilo),
    .wb_cp0_reg_we_o(wb_cp0_we), .wb_cp0_reg_write_addr_o(wb_cp0_wa),
    .wb_cp0_reg_data_o(wb_cp0_d),
    .stallreq_o(stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_byte(input logic [7:0] op);
    return op == LB || op == LBU || op == SB;
  endfunction
  function automatic bit is_half(input logic [7:0] op);
    return op == LH || op == LHU || op == SH;
  endfunction
  function automatic bit is_st(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [1:0] a);
    if (is_byte(op)) return 4'b1000 >> a;
    if (is_half(op)) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r);
    if (is_byte(op)) return {4{r[7:0]}};
    if (is_half(op)) return {2{r[15:0]}};
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (is_st(op)) return 32'h0;
    if (is_byte(op)) begin
      v = (rd >> (8 * (3 - int'(a)))) & 32'hFF;
      if (op == LB && v[7]) v = v | 32'hFFFFFF00;
    end else if (is_half(op)) begin
      v = (rd >> (a[1] ? 0 : 16)) & 32'hFFFF;
      if (op == LH && v[15]) v = v | 32'hFFFF0000;
    end else v = rd;
    return v;
  endfunction

  // the one model compare process: every cycle, away from the active edge
  always @(negedge clk) if (chk_en) begin
    chk("stallreq", stallreq, e_stall);
    chk("dbus_req", req_o, e_req);
    if (e_req) begin
      chk("dbus_we", we_o, e_we);
      chk("dbus_addr", addr_o, e_addr);
      chk("dbus_sel", sel_o, e_sel);
      if (e_we) chk("dbus_wdata", wdata_o, e_wdata);
    end
    chk("wb_wdata", wb_wdata, e_wb);
    chk("wb_pass", {wb_wd, wb_wreg, wb_hi, wb_lo, wb_whilo, wb_cp0_we, wb_cp0_wa, wb_cp0_d},
        rst ? 109'h0 : {wd, wreg, hi, lo, whilo, cp0_we, cp0_wa, cp0_d});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pass(input logic [31:0] s);
    wd = s[4:0]; wreg = s[5]; hi = s ^ 32'hA5A5A5A5; lo = ~s; whilo = s[6];
    cp0_we = s[7]; cp0_wa = s[12:8]; cp0_d = s + 32'h1000;
  endtask

  // One memory op: issue cycle, `waits` cycles without ack, ack cycle, `holds` frozen cycles.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] a, r2, rd,
                         input int waits, holds,
                         input logic [31:0] lit_wb, lit_addr, lit_wdata, input logic [3:0] lit_sel);
    logic [31:0] ld;
    ld = m_load(op, a[1:0], rd);
    aluop = op; maddr = a; reg2 = r2; ack = 0; stall = 0; wdata = 32'h5555AAAA;
    set_pass(a ^ r2);
    e_stall = 1; e_req = 0; e_wb = 0;
    tick();
    e_we = is_st(op); e_addr = {a[31:2], 2'b00}; e_sel = m_sel(op, a[1:0]); e_wdata = m_wdata(op, r2);
    for (int i = 0; i < waits; i++) begin
      e_req = 1; e_stall = 1; e_wb = 0;
      tick();
    end
    ack = 1; rdata = rd; stall = (holds > 0) ? 6'b011111 : 6'b0;
    e_req = 1; e_stall = 0; e_wb = ld;
    #1;
    chk("lit_wb", wb_wdata, lit_wb);
    chk("lit_addr", addr_o, lit_addr);
    chk("lit_sel", sel_o, lit_sel);
    if (is_st(op)) chk("lit_wdata", wdata_o, lit_wdata);
    tick();
    ack = 0; rdata = 32'hBAD0BAD0;
    for (int h = 1; h <= holds; h++) begin
      stall = (h < holds) ? 6'b011111 : 6'b0;
      e_req = 0; e_stall = 0; e_wb = ld;
      tick();
    end
    e_req = 0;
  endtask

  initial begin
    // reset, with a memory op already on the inputs: nothing may start
    aluop = LW; maddr = 32'h40; set_pass(32'h1F3);
    e_stall = 0; e_req = 0; e_wb = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;

    // plain ALU op: combinational pass-through, no bus traffic
    aluop = ALU; wdata = 32'h1234; set_pass(32'h25); wreg = 1; wd = 5;
    e_stall = 0; e_req = 0; e_wb = 32'h1234;
    #1;
    chk("alu_wb", wb_wdata, 32'h1234);
    chk("alu_wd", {wb_wreg, wb_wd}, {1'b1, 5'd5});
    tick();
    tick();

    run_mem(LB,  32'h103, 32'h0, 32'h000000F0, 0, 0, 32'hFFFFFFF0, 32'h100, 32'h0, 4'b0001);
    run_mem(LBU, 32'h103, 32'h0, 32'h000000F0, 0, 0, 32'h000000F0, 32'h100, 32'h0, 4'b0001);
    run_mem(SH,  32'h202, 32'hAAAA5678, 32'h0, 3, 0, 32'h0, 32'h200, 32'h56785678, 4'b0011);
    run_mem(LW,  32'h300, 32'h0, 32'hDEADBEEF, 1, 2, 32'hDEADBEEF, 32'h300, 32'h0, 4'b1111);
    run_mem(LH,  32'h500, 32'h0, 32'h80010000, 0, 0, 32'hFFFF8001, 32'h500, 32'h0, 4'b1100);
    run_mem(LHU, 32'h507, 32'h0, 32'h1234ABCD, 2, 0, 32'h0000ABCD, 32'h504, 32'h0, 4'b0011);
    run_mem(SB,  32'h601, 32'h123456EE, 32'h0, 0, 1, 32'h0, 32'h600, 32'hEEEEEEEE, 4'b0100);
    run_mem(SW,  32'h70B, 32'hCAFEF00D, 32'h0, 1, 0, 32'h0, 32'h708, 32'hCAFEF00D, 4'b1111);
    // back-to-back loads: the second issue cycle keeps req low
    run_mem(LW,  32'h400, 32'h0, 32'h11111111, 1, 0, 32'h11111111, 32'h400, 32'h0, 4'b1111);
    run_mem(LW,  32'h404, 32'h0, 32'h22222222, 0, 0, 32'h22222222, 32'h404, 32'h0, 4'b1111);

    // reset in the middle of a transaction, then a late ack
    aluop = LW; maddr = 32'h800; reg2 = 0; ack = 0; stall = 0; set_pass(32'h77);
    e_stall = 1; e_req = 0; e_wb = 0;
    tick();
    e_we = 0; e_addr = 32'h800; e_sel = 4'b1111; e_req = 1;
    tick();
    rst = 1; e_stall = 0; e_wb = 0;
    tick();
    rst = 0; aluop = ALU; wdata = 32'h00C0FFEE; ack = 1; rdata = 32'h99999999;
    e_req = 0; e_stall = 0; e_wb = 32'h00C0FFEE;
    #1;
    chk("late_ack_req", req_o, 1'b0);
    chk("late_ack_wb", wb_wdata, 32'h00C0FFEE);
    tick();
    ack = 0;
    tick();
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
